// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register chain: DEPTH stages, each a main register plus a skid register,
// with registered ready, synchronous flush and an occupancy count.
module pipe_stage_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    localparam int CW = $clog2(2 * DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CW-1:0]    count_o
);

    logic in_xfer;
    logic out_xfer;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             main_valid;
        logic             skid_valid;
        logic [WIDTH-1:0] main_data;
        logic [WIDTH-1:0] skid_data;
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_ready;
        logic             take;
        logic             load_main;

        if (k == 0) begin : g_head
            assign up_valid = in_valid_i;
            assign up_data  = in_data_i;
        end else begin : g_body
            assign up_valid = g_stage[k-1].main_valid;
            assign up_data  = g_stage[k-1].main_data;
        end

        // Ready seen by this stage comes from the next stage's skid flag, never combinationally.
        if (k == DEPTH - 1) begin : g_tail
            assign down_ready = out_ready_i;
        end else begin : g_link
            assign down_ready = ~g_stage[k+1].skid_valid;
        end

        assign take      = up_valid & ~skid_valid;
        assign load_main = ~main_valid | down_ready;

        // NOTE: payload registers are reset and flushed along with the valid bits, so an
        // empty chain presents 0 on out_data_o rather than stale data.
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
                main_data  <= '0;
                skid_data  <= '0;
            end else if (flush_i) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
                main_data  <= '0;
                skid_data  <= '0;
            end else if (load_main) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else if (take) begin
                    main_valid <= 1'b1;
                    main_data  <= up_data;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (take) begin
                skid_valid <= 1'b1;
                skid_data  <= up_data;
            end
        end
    end

    // Flush blocks both handshakes in the cycle it is asserted.
    assign in_ready_o  = ~g_stage[0].skid_valid & ~flush_i;
    assign out_valid_o = g_stage[DEPTH-1].main_valid & ~flush_i;
    assign out_data_o  = g_stage[DEPTH-1].main_data;

    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_o <= '0;
        end else if (flush_i) begin
            count_o <= '0;
        end else begin
            count_o <= count_o + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios on a DEPTH=3 chain plus
// randomized traffic on several DEPTH/WIDTH variants against a queue-based FIFO model.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    int n_vec = 0;
    int n_err = 0;
    int sel = 0;

    always #5 clk = ~clk;

    logic        r3, v3, r1, v1, r2, v2, r4, v4;
    logic [31:0] q3, q1, q4;
    logic [0:0]  q2;
    logic [2:0]  c3, c2;
    logic [1:0]  c1;
    logic [3:0]  c4;

    pipe_stage_elastic #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk_i(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r3),
        .in_data_i(in_data), .out_valid_o(v3), .out_ready_i(out_ready), .out_data_o(q3),
        .count_o(c3));
    pipe_stage_elastic #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk_i(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r1),
        .in_data_i(in_data), .out_valid_o(v1), .out_ready_i(out_ready), .out_data_o(q1),
        .count_o(c1));
    pipe_stage_elastic #(.WIDTH(1), .DEPTH(2)) u_d2 (
        .clk_i(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r2),
        .in_data_i(in_data[0:0]), .out_valid_o(v2), .out_ready_i(out_ready), .out_data_o(q2),
        .count_o(c2));
    pipe_stage_elastic #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r4),
        .in_data_i(in_data), .out_valid_o(v4), .out_ready_i(out_ready), .out_data_o(q4),
        .count_o(c4));

    logic        o_ready, o_valid;
    logic [31:0] o_data;
    logic [3:0]  o_count;

    always_comb begin
        o_ready = r3;
        o_valid = v3;
        o_data  = q3;
        o_count = {1'b0, c3};
        case (sel)
            1: begin o_ready = r1; o_valid = v1; o_data = q1; o_count = {2'b0, c1}; end
            2: begin o_ready = r2; o_valid = v2; o_data = {31'b0, q2}; o_count = {1'b0, c2}; end
            3: begin o_ready = r4; o_valid = v4; o_data = q4; o_count = c4; end
            default: ;
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        sel = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", o_ready); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", o_valid); end
        n_vec++; if (o_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_vec++; if (o_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %0h want 0", o_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", o_ready); end
        n_vec++; if (o_count !== 4'd0) begin n_err++; $display("FAIL post_reset_count: got %0d want 0", o_count); end
    endtask

    // Entry pushed in iteration i is accepted at the following edge and shows DEPTH-1=2 edges later.
    task automatic test_latency();
        sel = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (o_valid !== (i >= 3 && i <= 10)) begin
                n_err++; $display("FAIL latency_valid[%0d]: got %b want %b", i, o_valid, (i >= 3 && i <= 10));
            end
            if (i >= 3 && i <= 10) begin
                n_vec++;
                if (o_data !== 32'(i - 2)) begin n_err++; $display("FAIL latency_data[%0d]: got %0h want %0h", i, o_data, i - 2); end
            end
            n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL latency_in_ready[%0d]: got %b want 1", i, o_ready); end
            in_valid = (i < 8);
            in_data  = 32'(i + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_stalled(input logic [31:0] base, output int acc);
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(acc);
            #1;
            if (o_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc;
        logic [31:0] exp;
        sel = 0;
        do_reset();
        fill_stalled(32'h10, acc);
        n_vec++; if (acc !== 6) begin n_err++; $display("FAIL full_accepted: got %0d want 6", acc); end
        n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", o_ready); end
        n_vec++; if (o_count !== 4'd6) begin n_err++; $display("FAIL full_count: got %0d want 6", o_count); end
        out_ready = 1'b1;
        exp = 32'h10;
        for (int i = 0; i < 20; i++) begin
            if (o_valid) begin
                n_vec++;
                if (o_data !== exp) begin n_err++; $display("FAIL drain_data: got %0h want %0h", o_data, exp); end
                exp++;
            end
            @(negedge clk);
        end
        n_vec++; if (exp !== 32'h16) begin n_err++; $display("FAIL drain_total: got %0h want 16", exp); end
        n_vec++; if (o_count !== 4'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", o_count); end
    endtask

    task automatic test_flush();
        int acc;
        int n_out;
        sel = 0;
        do_reset();
        fill_stalled(32'h20, acc);
        n_vec++; if (o_count !== 4'd6) begin n_err++; $display("FAIL flush_prefill_count: got %0d want 6", o_count); end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        #1;
        n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", o_ready); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", o_valid); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_vec++; if (o_count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", o_count); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_after_valid: got %b want 0", o_valid); end
        n_vec++; if (o_data !== 32'd0) begin n_err++; $display("FAIL flush_after_data: got %0h want 0", o_data); end
        in_valid = 1'b1; in_data = 32'hAA;
        #1;
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL flush_repush_ready: got %b want 1", o_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_out = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_valid) begin
                n_out++;
                n_vec++;
                if (o_data !== 32'hAA) begin n_err++; $display("FAIL flush_repush_data: got %0h want aa", o_data); end
            end
            @(negedge clk);
        end
        n_vec++; if (n_out !== 1) begin n_err++; $display("FAIL flush_repush_count: got %0d outputs want 1", n_out); end
        n_vec++; if (o_count !== 4'd0) begin n_err++; $display("FAIL flush_final_count: got %0d want 0", o_count); end
    endtask

    task automatic test_async_reset();
        sel = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'h30 + 32'(i);
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b want 0", o_valid); end
        n_vec++; if (o_count !== 4'd0) begin n_err++; $display("FAIL async_rst_count: got %0d want 0", o_count); end
        n_vec++; if (o_data !== 32'd0) begin n_err++; $display("FAIL async_rst_data: got %0h want 0", o_data); end
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready: got %b want 1", o_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_ghost: got valid data %0h", o_data); end
        end
    endtask

    task automatic test_random(input int s, input int depth, input int cycles);
        logic [31:0] q[$];
        logic [31:0] mask;
        logic [31:0] prev_data;
        logic        prev_stall;
        logic        r0, inx, outx;
        int          cap, vprob, rprob;
        sel = s;
        cap = 2 * depth;
        mask = (s == 2) ? 32'h1 : 32'hFFFF_FFFF;
        vprob = $urandom_range(40, 95);
        rprob = $urandom_range(30, 95);
        do_reset();
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            n_vec++;
            if (o_count !== 4'(q.size())) begin
                n_err++; $display("FAIL rnd_count[s%0d c%0d]: got %0d want %0d", s, cyc, o_count, q.size());
            end
            flush     = ($urandom_range(0, 99) < 2);
            in_valid  = ($urandom_range(0, 99) < vprob);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < rprob);
            #1;
            if (flush) begin
                n_vec++;
                if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
                    n_err++; $display("FAIL rnd_flush_gate[s%0d c%0d]: got ready %b valid %b want 0 0", s, cyc, o_ready, o_valid);
                end
            end else if (q.size() == cap) begin
                n_vec++;
                if (o_ready !== 1'b0) begin n_err++; $display("FAIL rnd_full_ready[s%0d c%0d]: got %b want 0", s, cyc, o_ready); end
            end
            if (prev_stall && !flush) begin
                n_vec++;
                if (o_valid !== 1'b1 || o_data !== prev_data) begin
                    n_err++; $display("FAIL rnd_stall_stable[s%0d c%0d]: got %b/%0h want 1/%0h", s, cyc, o_valid, o_data, prev_data);
                end
            end
            r0 = o_ready;
            out_ready = ~out_ready;
            #1;
            n_vec++;
            if (o_ready !== r0) begin n_err++; $display("FAIL rnd_ready_indep[s%0d c%0d]: got %b want %b", s, cyc, o_ready, r0); end
            out_ready = ~out_ready;
            #1;
            inx  = in_valid & o_ready;
            outx = o_valid & out_ready;
            if (outx) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious[s%0d c%0d]: got %0h want no entry", s, cyc, o_data);
                end else begin
                    if (o_data !== q[0]) begin
                        n_err++; $display("FAIL rnd_order[s%0d c%0d]: got %0h want %0h", s, cyc, o_data, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (flush) q.delete();
            else if (inx) q.push_back(in_data & mask);
            prev_stall = o_valid & ~out_ready & ~flush;
            prev_data  = o_data;
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4 * depth + 8; i++) begin
            #1;
            if (o_valid) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_drain_extra[s%0d]: got %0h want no entry", s, o_data);
                end else begin
                    if (o_data !== q[0]) begin n_err++; $display("FAIL rnd_drain_order[s%0d]: got %0h want %0h", s, o_data, q[0]); end
                    void'(q.pop_front());
                end
            end
            @(negedge clk);
        end
        n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_lost[s%0d]: got %0d entries missing want 0", s, q.size()); end
        n_vec++; if (o_count !== 4'd0) begin n_err++; $display("FAIL rnd_final_count[s%0d]: got %0d want 0", s, o_count); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random(0, 3, 10000);
        test_random(1, 1, 10000);
        test_random(2, 2, 10000);
        test_random(3, 4, 10000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
